redundant_mem_seq: RTL and testbench
====================================

// Module: redundant_mem_seq
// PURPOSE
//  Parametrised lockstep memory sequencer: LANES identical lanes, each with an FSM, address counter and private RAM.
//  Each lane fills its RAM with a seed-derived pattern, then reads it back top-down; lane 0 drives the functional output.
//  A cross-lane comparator flags FSM-state or read-data divergence with per-lane attribution, a sticky fault and a counter.
//  Sits between the control sequencer and the safety monitor; co_fault feeds the fault aggregator.
// PARAMETERS
//  DW     8  data width of each RAM word / fo_data
//  AW     8  address width; RAM depth = 2**AW
//  LANES  2  redundant lane count; LANES<2 is an elaboration error ($fatal)
// PORTS
//  clk              in   1      clock, all logic on posedge
//  rst              in   1      synchronous reset, active-high
//  start            in   1      launch a run; sampled only in IDLE
//  seed             in   DW     pattern seed, captured into each lane on the start cycle
//  clear_fault      in   1      clears co_fault and fault_lane_mask (not fault_cnt)
//  busy             out  1      high in LOAD/EXEC/DONE of lane 0
//  done             out  1      one-cycle pulse in lane-0 DONE
//  fo_valid         out  1      high in lane-0 EXEC
//  fo_data          out  DW     lane-0 read data while fo_valid, else '0
//  co_fault         out  1      sticky divergence flag
//  fault_lane_mask  out  LANES  bit k sticky-set when lane k diverged from lane 0; bit 0 always 0
//  fault_cnt        out  8      saturating count of cycles with any divergence
// BEHAVIOUR
//  Reset: all lanes IDLE, addr 0, captured seed 0; busy/done/fo_valid/co_fault=0, fo_data='0, mask='0, fault_cnt=0.
//  RAM contents are not reset; no check reads RAM before the first LOAD completes.
//  FSM per lane: IDLE -start-> LOAD; LOAD: write mem[addr]=pat(addr), addr++; at addr=2**AW-1 write, then ->EXEC (addr held).
//  EXEC: async read mem[addr]; addr-- each cycle; after reading addr 0 -> DONE; DONE -> IDLE unconditionally (1 cycle).
//  Run length: 2**AW LOAD + 2**AW EXEC + 1 DONE cycles; start outside IDLE is ignored.
//  pat(a) = seed_q ^ a_ext; a_ext = a zero-extended to DW if AW<=DW, else truncated to its DW LSBs.
//  Address counter is AW bits; no wrap occurs because transitions fire at the end values.
//  Divergence(k) in a cycle = state_k != state_0, or (state_0==EXEC and rdata_k != rdata_0).
//  Any divergence: co_fault and mask[k] set on next edge; fault_cnt increments by 1 (sat. at 255).
//  clear_fault and a new divergence in the same cycle: set wins.
//  Reset mid-run: every lane returns to IDLE on the next edge; the partial RAM image is discarded logically.
// CONFIGURATION
//  FAULT_INJECT_EN defined: extra ports inj_en (in,1) and inj_mask (in,DW);
//   when inj_en=1, lane LANES-1 read data is XORed with inj_mask before compare (never reaches fo_data unless LANES-1==0, illegal).
//  Not defined: ports absent, lanes are bit-identical, no injection path synthesised.
// STRUCTURE
//  Package redundant_mem_pkg: typedef enum logic [1:0] {IDLE=2'b00, LOAD=2'b01, EXEC=2'b10, DONE=2'b11} seq_state_t;
//   plus function pat(seed, addr) with DW/AW as arguments via parameterised class or width-generic function.
//  Sub-module mem_seq_lane #(DW,AW): FSM, counter, seed register, RAM, exports state and rdata.
//  Top generates LANES instances, comparator, sticky flags, saturating counter, assertions (no-deadlock, write-correct).
// TESTING
//  1 DW=8,AW=4,LANES=2, seed=8'hA5, start 1 cycle -> done pulses exactly 33 cycles after start; co_fault stays 0.
//  2 Same run: fo_data sequence during fo_valid = A5^0F, A5^0E, ... A5^00 (AA..A5), 16 beats.
//  3 FAULT_INJECT_EN, LANES=3, inj_mask=8'h01 for one EXEC cycle -> next cycle co_fault=1, mask=3'b100, fault_cnt=1.
//  4 clear_fault asserted alone after test 3 -> co_fault=0, mask=0, fault_cnt stays 1; clear+inj same cycle -> co_fault=1.
//  5 rst pulsed mid-LOAD (addr=7) -> next cycle busy=0, IDLE; new start with seed 8'h3C completes cleanly, data=3C^addr.
//  6 start held high continuously -> back-to-back runs with one IDLE cycle between done and next LOAD; start while busy ignored.

Source files
------------

// File: rtl/redundant_mem_pkg.sv
// Shared state encoding and pattern helper for the redundant memory sequencer lanes.
package redundant_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EXEC = 2'b10,
    DONE = 2'b11
  } seq_state_t;

  localparam int unsigned PAT_MAX_W   = 64;
  localparam int unsigned FAULT_CNT_W = 8;

  // Width-generic: callers zero-extend both operands to PAT_MAX_W and keep the DW LSBs,
  // which zero-extends or truncates the address as the data width requires.
  function automatic logic [PAT_MAX_W-1:0] pat(input logic [PAT_MAX_W-1:0] seed,
                                               input logic [PAT_MAX_W-1:0] addr);
    return seed ^ addr;
  endfunction

endpackage

// File: rtl/mem_seq_lane.sv
// One sequencer lane: fills its private RAM with seed^addr, then reads it back top-down.
module mem_seq_lane
  import redundant_mem_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  output seq_state_t    state,
  output logic [DW-1:0] rdata
);

  localparam int unsigned   DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  seq_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] seed_q, seed_d;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] patWord;
  logic          memWe;

  assign patWord = DW'(pat(PAT_MAX_W'(seed_q), PAT_MAX_W'(addr_q)));

  // Transitions fire at the end addresses, so the counter never wraps.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    memWe   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          addr_d  = '0;
          seed_d  = seed;
        end
      end
      LOAD: begin
        memWe = 1'b1;
        if (addr_q == ADDR_MAX) state_d = EXEC;
        else                    addr_d  = addr_q + 1'b1;
      end
      EXEC: begin
        if (addr_q == '0) state_d = DONE;
        else              addr_d  = addr_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[addr_q] <= patWord;
  end

  assign rdata = mem[addr_q];
  assign state = state_q;

  // Readback must equal what LOAD wrote; every busy cycle must move the state or the address.
  assert property (@(posedge clk) disable iff (rst) (state_q == EXEC) |-> (rdata == patWord));
  assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |=> ((state_q != $past(state_q)) || (addr_q != $past(addr_q))));

endmodule

// File: rtl/redundant_mem_seq.sv
// Lockstep memory sequencer: LANES identical lanes, lane 0 drives the output, others are compared.
// Optional FAULT_INJECT_EN adds inj_en/inj_mask to corrupt the last lane's compared read data.
module redundant_mem_seq
  import redundant_mem_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DW-1:0]          seed,
  input  logic                   clear_fault,
`ifdef FAULT_INJECT_EN
  input  logic                   inj_en,
  input  logic [DW-1:0]          inj_mask,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   fo_valid,
  output logic [DW-1:0]          fo_data,
  output logic                   co_fault,
  output logic [LANES-1:0]       fault_lane_mask,
  output logic [FAULT_CNT_W-1:0] fault_cnt
);

  if (LANES < 2) begin : g_lanes_check
    $fatal(1, "redundant_mem_seq: LANES must be at least 2");
  end

  seq_state_t             laneState [LANES];
  logic [DW-1:0]          laneData  [LANES];
  logic [DW-1:0]          cmpData   [LANES];
  logic [LANES-1:0]       diverge;
  logic                   anyDiverge;
  logic                   coFault_q, coFault_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [FAULT_CNT_W-1:0] faultCnt_q, faultCnt_d;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mem_seq_lane #(.DW(DW), .AW(AW)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .seed  (seed),
      .state (laneState[k]),
      .rdata (laneData[k])
    );
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) cmpData[k] = laneData[k];
`ifdef FAULT_INJECT_EN
    if (inj_en) cmpData[LANES-1] = laneData[LANES-1] ^ inj_mask;
`endif
  end

  // Lane 0 is the reference, so bit 0 of the divergence vector stays low.
  always_comb begin
    diverge = '0;
    for (int k = 1; k < LANES; k++) begin
      diverge[k] = (laneState[k] != laneState[0]) ||
                   ((laneState[0] == EXEC) && (cmpData[k] != cmpData[0]));
    end
  end

  assign anyDiverge = |diverge;

  // A fresh divergence overrides a simultaneous clear.
  always_comb begin
    coFault_d  = (coFault_q & ~clear_fault) | anyDiverge;
    mask_d     = (clear_fault ? '0 : mask_q) | diverge;
    faultCnt_d = faultCnt_q;
    if (anyDiverge && (faultCnt_q != {FAULT_CNT_W{1'b1}})) faultCnt_d = faultCnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coFault_q  <= 1'b0;
      mask_q     <= '0;
      faultCnt_q <= '0;
    end else begin
      coFault_q  <= coFault_d;
      mask_q     <= mask_d;
      faultCnt_q <= faultCnt_d;
    end
  end

  assign busy            = (laneState[0] != IDLE);
  assign done            = (laneState[0] == DONE);
  assign fo_valid        = (laneState[0] == EXEC);
  assign fo_data         = fo_valid ? laneData[0] : '0;
  assign co_fault        = coFault_q;
  assign fault_lane_mask = mask_q;
  assign fault_cnt       = faultCnt_q;

  assert property (@(posedge clk) disable iff (rst) done |=> !busy);
  assert property (@(posedge clk) !fault_lane_mask[0]);

endmodule

// File: tb/tb_redundant_mem_seq.sv
// Scoreboard bench for redundant_mem_seq; define FAULT_INJECT_EN to also exercise injection.
module tb_redundant_mem_seq;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef FAULT_INJECT_EN
  localparam int LANES = 3;
`else
  localparam int LANES = 2;
`endif

  typedef struct {
    bit            isDone;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [DW-1:0]    seed;
  logic             clearFault;
`ifdef FAULT_INJECT_EN
  logic             injEn;
  logic [DW-1:0]    injMask;
`endif
  logic             busy;
  logic             done;
  logic             foValid;
  logic [DW-1:0]    foData;
  logic             coFault;
  logic [LANES-1:0] faultMask;
  logic [7:0]       faultCnt;

  exp_t expQ[$];
  exp_t expItem;
  int   cycleNo    = 0;
  int   vectors    = 0;
  int   miscompares = 0;
  bit   faultQuiet = 1'b1;

  redundant_mem_seq #(.DW(DW), .AW(AW), .LANES(LANES)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .seed            (seed),
    .clear_fault     (clearFault),
`ifdef FAULT_INJECT_EN
    .inj_en          (injEn),
    .inj_mask        (injMask),
`endif
    .busy            (busy),
    .done            (done),
    .fo_valid        (foValid),
    .fo_data         (foData),
    .co_fault        (coFault),
    .fault_lane_mask (faultMask),
    .fault_cnt       (faultCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // A run started on cycle c reads back seed^addr for addr = DEPTH-1 .. 0, then pulses done.
  task automatic pushRun(input logic [DW-1:0] s, input int startCyc);
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.isDone = 1'b0;
      e.data   = s ^ DW'(DEPTH - 1 - i);
      e.cyc    = startCyc + DEPTH + 1 + i;
      expQ.push_back(e);
    end
    e.isDone = 1'b1;
    e.data   = '0;
    e.cyc    = startCyc + 2 * DEPTH + 1;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] s);
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    pushRun(s, cycleNo);
    @(negedge clk);
    start = 1'b0;
    seed  = DW'($urandom);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or a done pulse.
  always begin
    @(posedge clk);
    #1;
    if (foValid || done) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected output: got valid=%0b done=%0b data=%h at cycle %0d, expected none",
                 foValid, done, foData, cycleNo);
      end else begin
        expItem = expQ.pop_front();
        if ((expItem.isDone != done) || (expItem.cyc != cycleNo) ||
            (!expItem.isDone && (expItem.data != foData)) || (expItem.isDone && !busy)) begin
          miscompares++;
          $display("[TB] FAIL scoreboard: got done=%0b data=%h busy=%0b at cycle %0d, expected done=%0b data=%h at cycle %0d",
                   done, foData, busy, cycleNo, expItem.isDone, expItem.data, expItem.cyc);
        end
      end
    end
    if (!foValid) checkOutput("fo_data idle", 32'(foData), 32'd0);
    if (faultQuiet) checkOutput("fault outputs quiet", {coFault, 8'(faultMask), faultCnt}, 32'd0);
  end

  initial begin
    logic [DW-1:0] s;
    int            n;
    rst        = 1'b1;
    start      = 1'b0;
    seed       = '0;
    clearFault = 1'b0;
`ifdef FAULT_INJECT_EN
    injEn      = 1'b0;
    injMask    = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset fo_valid", 32'(foValid), 32'd0);
    checkOutput("reset fo_data", 32'(foData), 32'd0);
    checkOutput("reset co_fault", 32'(coFault), 32'd0);
    checkOutput("reset mask", 32'(faultMask), 32'd0);
    checkOutput("reset fault_cnt", 32'(faultCnt), 32'd0);
    rst = 1'b0;

    applyStimulus(8'hA5);
    repeat (2 * DEPTH + 1) @(negedge clk);
    checkOutput("idle after A5 run", 32'(busy), 32'd0);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(DW'($urandom));
      repeat (2 * DEPTH + 1) @(negedge clk);
      checkOutput("idle after random run", 32'(busy), 32'd0);
    end

    // Reset while lane 0 is loading address 7 abandons the run.
    applyStimulus(DW'($urandom));
    repeat (7) @(negedge clk);
    checkOutput("busy mid load", 32'(busy), 32'd1);
    rst = 1'b1;
    expQ.delete();
    @(negedge clk);
    checkOutput("busy after mid reset", 32'(busy), 32'd0);
    checkOutput("fo_valid after mid reset", 32'(foValid), 32'd0);
    rst = 1'b0;
    applyStimulus(8'h3C);
    repeat (2 * DEPTH + 1) @(negedge clk);
    checkOutput("idle after 3C run", 32'(busy), 32'd0);

    // Start held high: runs repeat with exactly one idle cycle after each done.
    @(negedge clk);
    s     = DW'($urandom);
    start = 1'b1;
    seed  = s;
    n     = cycleNo;
    for (int r = 0; r < 3; r++) pushRun(s, n + r * (2 * DEPTH + 2));
    repeat (2 * (2 * DEPTH + 2) + 1) @(negedge clk);
    start = 1'b0;
    repeat (2 * DEPTH + 1) @(negedge clk);
    checkOutput("idle after held start", 32'(busy), 32'd0);

`ifdef FAULT_INJECT_EN
    applyStimulus(DW'($urandom));
    repeat (DEPTH + 3) @(negedge clk);
    checkOutput("in exec before inject", 32'(foValid), 32'd1);
    faultQuiet = 1'b0;
    injEn   = 1'b1;
    injMask = 8'h01;
    @(negedge clk);
    injEn = 1'b0;
    checkOutput("inject co_fault", 32'(coFault), 32'd1);
    checkOutput("inject mask", 32'(faultMask), 32'(1 << (LANES - 1)));
    checkOutput("inject fault_cnt", 32'(faultCnt), 32'd1);
    clearFault = 1'b1;
    @(negedge clk);
    checkOutput("clear co_fault", 32'(coFault), 32'd0);
    checkOutput("clear mask", 32'(faultMask), 32'd0);
    checkOutput("clear keeps fault_cnt", 32'(faultCnt), 32'd1);
    injEn = 1'b1;
    @(negedge clk);
    injEn      = 1'b0;
    clearFault = 1'b0;
    checkOutput("set beats clear co_fault", 32'(coFault), 32'd1);
    checkOutput("set beats clear mask", 32'(faultMask), 32'(1 << (LANES - 1)));
    checkOutput("second fault_cnt", 32'(faultCnt), 32'd2);
    repeat (DEPTH - 5) @(negedge clk);
    checkOutput("idle after inject run", 32'(busy), 32'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
